// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: valid/ready word load, MSB-first shift paced by i_shift_en.
// Supports back-to-back words with no gap bit and a one-cycle o_done pulse per word.
module piso_shift_tx #(
   parameter int unsigned RegWidth = 4
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic [RegWidth-1:0] i_d,
   input  logic                i_load_valid,
   output logic                o_load_ready,
   input  logic                i_shift_en,
   output logic                o_q,
   output logic                o_frame_out,
   output logic                o_done
);

   localparam int unsigned CntW = $clog2(RegWidth);
   localparam logic [CntW-1:0] CntLast = CntW'(RegWidth - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e              r_state;
   logic [RegWidth-1:0] r_shadow;
   logic [CntW-1:0]     r_bit_cnt;
   logic                r_done;

   logic w_last_bit;
   logic w_accept;

   assign w_last_bit   = (r_state == StShift) && (r_bit_cnt == '0) && i_shift_en;
   assign o_load_ready = (r_state == StIdle) || w_last_bit;
   assign w_accept     = i_load_valid && o_load_ready;

   assign o_q         = (r_state == StShift) && r_shadow[RegWidth-1];
   assign o_frame_out = (r_state == StShift);
   assign o_done      = r_done;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_state   <= StIdle;
         r_shadow  <= '0;
         r_bit_cnt <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_shadow  <= i_d;
                  r_bit_cnt <= CntLast;
                  r_state   <= StShift;
               end
            end
            StShift: begin
               if (i_shift_en) begin
                  if (r_bit_cnt == '0) begin
                     r_done <= 1'b1;
                     // A same-edge accept chains the next word without an idle bit.
                     if (w_accept) begin
                        r_shadow  <= i_d;
                        r_bit_cnt <= CntLast;
                     end else begin
                        r_shadow  <= '0;
                        r_state   <= StIdle;
                     end
                  end else begin
                     r_shadow  <= {r_shadow[RegWidth-2:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt - 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed self-checking bench for piso_shift_tx at widths 4 and 8.
module tb_piso_shift_tx;

   logic       clk = 1'b0;
   logic       resetN;
   logic [7:0] d;
   logic       valid;
   logic       shift_en;
   logic       sel8;

   logic ready4, q4, frame4, done4;
   logic ready8, q8, frame8, done8;
   logic ready_s, q_s, frame_s, done_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   piso_shift_tx #(.RegWidth(4)) u_dut4 (
      .clk          (clk),
      .resetN       (resetN),
      .i_d          (d[3:0]),
      .i_load_valid (valid & ~sel8),
      .o_load_ready (ready4),
      .i_shift_en   (shift_en),
      .o_q          (q4),
      .o_frame_out  (frame4),
      .o_done       (done4)
   );

   piso_shift_tx #(.RegWidth(8)) u_dut8 (
      .clk          (clk),
      .resetN       (resetN),
      .i_d          (d),
      .i_load_valid (valid & sel8),
      .o_load_ready (ready8),
      .i_shift_en   (shift_en),
      .o_q          (q8),
      .o_frame_out  (frame8),
      .o_done       (done8)
   );

   assign ready_s = sel8 ? ready8 : ready4;
   assign q_s     = sel8 ? q8 : q4;
   assign frame_s = sel8 ? frame8 : frame4;
   assign done_s  = sel8 ? done8 : done4;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Load one word from idle, optionally stall stall_n cycles while bit stall_at is presented.
   task automatic xmit(input int w, input logic [7:0] word, input int stall_at, input int stall_n);
      d = word; valid = 1'b1; shift_en = 1'b1;
      settle();
      check_eq("ready_idle", ready_s, 1'b1);
      tick();
      valid = 1'b0;
      settle();
      for (int i = 0; i < w; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
               shift_en = 1'b0;
               settle();
               check_eq("stall_q", q_s, word[w-1-i]);
               check_eq("stall_frame", frame_s, 1'b1);
               check_eq("stall_ready", ready_s, 1'b0);
               check_eq("stall_done", done_s, 1'b0);
               tick();
            end
            shift_en = 1'b1;
            settle();
         end
         check_eq("bit_q", q_s, word[w-1-i]);
         check_eq("bit_frame", frame_s, 1'b1);
         check_eq("bit_done", done_s, 1'b0);
         check_eq("bit_ready", ready_s, (i == w - 1));
         tick();
         settle();
      end
      check_eq("end_frame", frame_s, 1'b0);
      check_eq("end_q", q_s, 1'b0);
      check_eq("end_done", done_s, 1'b1);
      tick();
      settle();
      check_eq("done_once", done_s, 1'b0);
   endtask

   initial begin
      logic [7:0] exp8;
      sel8 = 1'b0;
      resetN = 1'b0;
      for (int i = 0; i < 2; i++) begin
         d = 8'($urandom); valid = 1'($urandom); shift_en = 1'($urandom);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         sel8 = k[0];
         settle();
         check_eq("rst_q", q_s, 1'b0);
         check_eq("rst_frame", frame_s, 1'b0);
         check_eq("rst_done", done_s, 1'b0);
         check_eq("rst_ready", ready_s, 1'b1);
      end
      sel8 = 1'b0;
      resetN = 1'b1; valid = 1'b0; shift_en = 1'b0;
      tick();

      // Single word and stall on width 4
      xmit(4, 8'b1011, -1, 0);
      xmit(4, 8'b1100, 1, 3);

      // Back-to-back: 1001 then 0110 with valid held high
      d = 8'b1001; valid = 1'b1; shift_en = 1'b1;
      tick();
      d = 8'b0110;
      settle();
      exp8 = 8'b1001_0110;
      for (int i = 0; i < 8; i++) begin
         check_eq("b2b_q", q_s, exp8[7-i]);
         check_eq("b2b_frame", frame_s, 1'b1);
         check_eq("b2b_done", done_s, (i == 4));
         check_eq("b2b_ready", ready_s, (i == 3 || i == 7));
         tick();
         if (i == 3) valid = 1'b0;
         settle();
      end
      check_eq("b2b_end_frame", frame_s, 1'b0);
      check_eq("b2b_end_done", done_s, 1'b1);
      tick();
      settle();
      check_eq("b2b_done_once", done_s, 1'b0);

      // Load while busy: 1111 offered during 0000 is only taken on the last-bit edge
      d = 8'b0000; valid = 1'b1; shift_en = 1'b1;
      tick();
      d = 8'b1111;
      settle();
      for (int i = 0; i < 4; i++) begin
         check_eq("busy_q", q_s, 1'b0);
         check_eq("busy_ready", ready_s, (i == 3));
         tick();
         if (i == 3) valid = 1'b0;
         settle();
      end
      check_eq("busy_done", done_s, 1'b1);
      check_eq("busy_frame", frame_s, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check_eq("busy_next_q", q_s, 1'b1);
         tick();
         settle();
      end
      check_eq("busy_next_done", done_s, 1'b1);
      check_eq("busy_next_frame", frame_s, 1'b0);
      tick();

      // Reset mid-frame, width 4 then width 8
      for (int k = 0; k < 2; k++) begin
         sel8 = k[0];
         d = sel8 ? 8'hA5 : 8'b1010; valid = 1'b1; shift_en = 1'b1;
         tick();
         valid = 1'b0;
         settle();
         check_eq("mid_bit0", q_s, 1'b1);
         tick();
         settle();
         check_eq("mid_bit1", q_s, 1'b0);
         tick();
         resetN = 1'b0;
         settle();
         tick();
         resetN = 1'b1;
         settle();
         check_eq("mid_rst_q", q_s, 1'b0);
         check_eq("mid_rst_frame", frame_s, 1'b0);
         check_eq("mid_rst_done", done_s, 1'b0);
         check_eq("mid_rst_ready", ready_s, 1'b1);
         tick();
         settle();
         check_eq("mid_rst_nodone", done_s, 1'b0);
         if (sel8) xmit(8, 8'hA5, -1, 0);
         else      xmit(4, 8'b1010, -1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
